// File: rtl/relu_maxpool.sv
// Streaming signed max-pool over windows of POOL samples, with early close on in_last.
// Single registered output slot behind a valid/ready handshake on each side.
module relu_maxpool #(
    parameter int WIDTH = 16,
    parameter int POOL  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       out_count
);

    localparam logic [7:0] LAST_IDX = 8'(POOL - 1);

    logic [WIDTH-1:0] acc_max_r;
    logic [7:0]       acc_cnt_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [7:0]       out_count_r;

    logic             ready_s;
    logic             accept_s;
    logic             close_s;
    logic [WIDTH-1:0] new_max_s;

    assign ready_s   = !out_valid_r || out_ready;
    assign in_ready  = ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_count = out_count_r;

    // Accept/close decode and running maximum (ties keep the held value)
    always_comb begin
        accept_s  = in_valid && ready_s;
        close_s   = 1'b0;
        new_max_s = acc_max_r;
        if (acc_cnt_r == 8'd0) begin
            new_max_s = in_data;
        end else if ($signed(in_data) > $signed(acc_max_r)) begin
            new_max_s = in_data;
        end else begin
            new_max_s = acc_max_r;
        end
        if (accept_s && ((acc_cnt_r == LAST_IDX) || in_last)) begin
            close_s = 1'b1;
        end else begin
            close_s = 1'b0;
        end
    end

    // Accumulator and output slot; a closing window takes priority over draining
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_max_r   <= {WIDTH{1'b0}};
            acc_cnt_r   <= 8'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_count_r <= 8'd0;
        end else begin
            if (accept_s) begin
                acc_max_r <= new_max_s;
                if (close_s) begin
                    acc_cnt_r <= 8'd0;
                end else begin
                    acc_cnt_r <= acc_cnt_r + 8'd1;
                end
            end
            if (close_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= new_max_s;
                out_count_r <= acc_cnt_r + 8'd1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed and randomised checks for relu_maxpool (POOL=4 instance plus a POOL=1 instance).
module tb_relu_maxpool;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_count;

    logic        p1_valid, p1_last, p1_out_ready;
    logic [15:0] p1_data;
    logic        p1_in_ready, p1_out_valid;
    logic [15:0] p1_out_data;
    logic [7:0]  p1_out_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    relu_maxpool #(.WIDTH(16), .POOL(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
    );

    relu_maxpool #(.WIDTH(16), .POOL(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(p1_valid), .in_ready(p1_in_ready),
        .in_data(p1_data), .in_last(p1_last), .out_valid(p1_out_valid),
        .out_ready(p1_out_ready), .out_data(p1_out_data), .out_count(p1_out_count)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic l);
        in_valid = 1'b1;
        in_data  = 16'(d);
        in_last  = l;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int d, input int c);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_data"}, $signed(out_data), d);
        chk({tag, "_count"}, 32'(out_count), c);
    endtask

    int exp_d[$];
    int exp_c[$];
    int m_max, m_cnt, accepted, cycles, d;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 16'd0; out_ready = 1'b1;
        p1_valid = 1'b0; p1_last = 1'b0; p1_data = 16'd0; p1_out_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", $signed(out_data), 0);
        chk("rst_count", 32'(out_count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        // Full windows
        send(3, 1'b0); send(9, 1'b0); send(2, 1'b0);
        chk("w1_early_valid", 32'(out_valid), 0);
        send(5, 1'b0);
        chk_out("w1", 9, 4);
        send(0, 1'b0);
        chk("w2_drain_valid", 32'(out_valid), 0);
        send(0, 1'b0); send(7, 1'b0); send(1, 1'b0);
        chk_out("w2", 7, 4);

        // Early close via in_last
        send(4, 1'b0); send(6, 1'b1);
        chk_out("last2", 6, 2);
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(8, 1'b0);
        chk_out("after_last", 8, 4);

        // Signed and ties
        send(-5, 1'b0); send(-2, 1'b0); send(-9, 1'b0); send(-3, 1'b0);
        chk_out("neg", -2, 4);
        send(7, 1'b0); send(7, 1'b0); send(7, 1'b0); send(7, 1'b0);
        chk_out("tie", 7, 4);

        // in_last on the POOL-th sample gives one close; then a 1-sample window
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b1);
        chk_out("last_on_4th", 4, 4);
        send(5, 1'b1);
        chk_out("single", 5, 1);
        in_valid = 1'b0; in_last = 1'b1; in_data = 16'd99;
        cyc();
        chk("idle_last_ignored", 32'(out_valid), 0);
        in_last = 1'b0;

        // Backpressure
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0);
        chk_out("bp_pre", 4, 4);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'd100; in_last = 1'b1;
        #1;
        chk("bp_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk_out("bp_hold", 4, 4);
        end
        out_ready = 1'b1; in_data = 16'd50;
        #1;
        chk("bp_release_ready", 32'(in_ready), 1);
        cyc();
        chk_out("bp_refill", 50, 1);
        in_valid = 1'b0; in_last = 1'b0;
        cyc();
        chk("bp_drained", 32'(out_valid), 0);

        // POOL=1 instance
        p1_valid = 1'b1; p1_data = 16'd2;
        cyc();
        chk("p1_a_valid", 32'(p1_out_valid), 1);
        chk("p1_a_data", $signed(p1_out_data), 2);
        chk("p1_a_count", 32'(p1_out_count), 1);
        p1_data = 16'hFFFF;
        cyc();
        chk("p1_b_data", $signed(p1_out_data), -1);
        chk("p1_b_count", 32'(p1_out_count), 1);
        p1_data = 16'd5;
        cyc();
        chk("p1_c_data", $signed(p1_out_data), 5);
        chk("p1_c_count", 32'(p1_out_count), 1);
        p1_valid = 1'b0;

        // Reset mid-window
        send(9, 1'b0); send(8, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rstw_valid", 32'(out_valid), 0);
        chk("rstw_data", $signed(out_data), 0);
        chk("rstw_count", 32'(out_count), 0);
        chk("rstw_in_ready", 32'(in_ready), 1);
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0);
        chk_out("rstw_next", 4, 4);

        // Reset with a pending result
        send(9, 1'b1);
        chk_out("rstv_pre", 9, 1);
        out_ready = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0; out_ready = 1'b1;
        chk("rstv_valid", 32'(out_valid), 0);
        chk("rstv_data", $signed(out_data), 0);
        chk("rstv_count", 32'(out_count), 0);
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0);
        chk_out("rstv_next", 4, 4);
        cyc();

        // Random handshake against a reference model
        m_max = 0; m_cnt = 0; accepted = 0; cycles = 0;
        while (accepted < 1000 && cycles < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            d         = int'($urandom_range(0, 200)) - 100;
            in_data   = 16'(d);
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                if (exp_d.size() == 0) begin
                    chk("rnd_unexpected", exp_d.size(), 1);
                end else begin
                    chk("rnd_data", $signed(out_data), exp_d.pop_front());
                    chk("rnd_count", 32'(out_count), exp_c.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                accepted++;
                if (m_cnt == 0 || d > m_max) m_max = d;
                m_cnt++;
                if (m_cnt == 4 || in_last) begin
                    exp_d.push_back(m_max);
                    exp_c.push_back(m_cnt);
                    m_cnt = 0;
                end
            end
            cyc();
            cycles++;
        end
        chk("rnd_accepted", accepted, 1000);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (out_valid) begin
                if (exp_d.size() == 0) begin
                    chk("drain_unexpected", exp_d.size(), 1);
                end else begin
                    chk("drain_data", $signed(out_data), exp_d.pop_front());
                    chk("drain_count", 32'(out_count), exp_c.pop_front());
                end
            end
            cyc();
        end
        chk("drain_empty", exp_d.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
